// File: rtl/branch_resolve_ctrl_if.sv
// Signal bundle between the ID-stage branch controller and the pipeline.
// Optional statistics outputs appear when BRANCH_STATS_EN is defined.
interface branch_resolve_ctrl_if;
    logic       id_beq;
    logic       id_bne;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       ex_reg_write;
    logic       ex_mem_read;
    logic [4:0] ex_rd;
    logic       mem_reg_write;
    logic       mem_mem_read;
    logic [4:0] mem_rd;
    logic       wb_reg_write;
    logic [4:0] wb_rd;
    logic       cmp_equal;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;
    logic       stall;
    logic       pc_src;
    logic       if_flush;
`ifdef BRANCH_STATS_EN
    logic [15:0] stat_taken;
    logic [15:0] stat_not_taken;
    logic [15:0] stat_stall_cycles;
`endif

    // Controller side
    modport slave (
        input  id_beq, id_bne, id_rs, id_rt,
        input  ex_reg_write, ex_mem_read, ex_rd,
        input  mem_reg_write, mem_mem_read, mem_rd,
        input  wb_reg_write, wb_rd, cmp_equal,
        output fwd_a_sel, fwd_b_sel, stall, pc_src, if_flush
`ifdef BRANCH_STATS_EN
        , output stat_taken, stat_not_taken, stat_stall_cycles
`endif
    );

    // Pipeline side
    modport master (
        output id_beq, id_bne, id_rs, id_rt,
        output ex_reg_write, ex_mem_read, ex_rd,
        output mem_reg_write, mem_mem_read, mem_rd,
        output wb_reg_write, wb_rd, cmp_equal,
        input  fwd_a_sel, fwd_b_sel, stall, pc_src, if_flush
`ifdef BRANCH_STATS_EN
        , input stat_taken, stat_not_taken, stat_stall_cycles
`endif
    );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch controller: hazard stall sequencing, comparator operand
// forwarding select, PC redirect and IF/ID flush for beq/bne.
// Optional macro BRANCH_STATS_EN adds saturating taken/not-taken/stall counters.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no stall pending; independent branches resolve here
// STALL   | extra bubble for a load in EX (cnt counts remaining bubbles)
// RESOLVE | operands now reachable via forwarding; sample comparator
module branch_resolve_ctrl (
    input  logic                    clk,
    input  logic                    rst_n,
    branch_resolve_ctrl_if.slave    bus
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STALL   = 2'd1,
        ST_RESOLVE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_cnt;
    logic [1:0] w_cnt_nxt;
    logic       w_branch;
    logic       w_ex_match;
    logic       w_mem_match;
    logic [1:0] w_need;
    logic       w_stall;
    logic       w_resolve;
    logic       w_pc_src;

    function automatic logic f_match(input logic [4:0] rd, input logic [4:0] rs,
                                     input logic [4:0] rt);
        return (rd != 5'd0) && ((rd == rs) || (rd == rt));
    endfunction

    // Register 0 never forwards; EX/MEM ALU results win over WB data.
    function automatic logic [1:0] f_fwd(input logic [4:0] src,
                                         input logic mem_rw, input logic mem_mr,
                                         input logic [4:0] mem_rd,
                                         input logic wb_rw, input logic [4:0] wb_rd);
        if (mem_rw && !mem_mr && (mem_rd != 5'd0) && (mem_rd == src))
            return 2'b01;
        else if (wb_rw && (wb_rd != 5'd0) && (wb_rd == src))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign w_branch    = bus.id_beq | bus.id_bne;
    assign w_ex_match  = f_match(bus.ex_rd, bus.id_rs, bus.id_rt);
    assign w_mem_match = f_match(bus.mem_rd, bus.id_rs, bus.id_rt);

    // Bubbles needed before the comparator operands become forwardable.
    always_comb begin
        w_need = 2'd0;
        if (bus.ex_reg_write && bus.ex_mem_read && w_ex_match)
            w_need = 2'd2;
        else if (bus.ex_reg_write && w_ex_match)
            w_need = 2'd1;
        else if (bus.mem_mem_read && w_mem_match)
            w_need = 2'd1;
    end

    // Next-state, counter and stall/resolve decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        w_resolve   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_branch) begin
                    if (w_need == 2'd0) begin
                        w_resolve = 1'b1;
                    end else begin
                        w_stall     = 1'b1;
                        w_cnt_nxt   = w_need - 2'd1;
                        w_state_nxt = (w_need == 2'd1) ? ST_RESOLVE : ST_STALL;
                    end
                end
            end
            ST_STALL: begin
                if (!w_branch) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 2'd0;
                end else begin
                    w_stall   = 1'b1;
                    w_cnt_nxt = (r_cnt != 2'd0) ? r_cnt - 2'd1 : 2'd0;
                    if (r_cnt <= 2'd1)
                        w_state_nxt = ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 2'd0;
                w_resolve   = w_branch;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 2'd0;
            end
        endcase
        // Outputs must read zero as soon as reset is applied, even mid-stall.
        if (!rst_n) begin
            w_stall   = 1'b0;
            w_resolve = 1'b0;
        end
    end

    assign w_pc_src      = w_resolve & (bus.cmp_equal ^ bus.id_bne);
    assign bus.stall     = w_stall;
    assign bus.pc_src    = w_pc_src;
    assign bus.if_flush  = w_pc_src;
    assign bus.fwd_a_sel = w_resolve ? f_fwd(bus.id_rs, bus.mem_reg_write, bus.mem_mem_read,
                                             bus.mem_rd, bus.wb_reg_write, bus.wb_rd) : 2'b00;
    assign bus.fwd_b_sel = w_resolve ? f_fwd(bus.id_rt, bus.mem_reg_write, bus.mem_mem_read,
                                             bus.mem_rd, bus.wb_reg_write, bus.wb_rd) : 2'b00;

    // State and stall counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [15:0] r_stat_taken;
    logic [15:0] r_stat_not_taken;
    logic [15:0] r_stat_stall;

    // Saturating event counters; cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_taken     <= 16'd0;
            r_stat_not_taken <= 16'd0;
            r_stat_stall     <= 16'd0;
        end else begin
            if (w_resolve && w_pc_src && (r_stat_taken != 16'hFFFF))
                r_stat_taken <= r_stat_taken + 16'd1;
            if (w_resolve && !w_pc_src && (r_stat_not_taken != 16'hFFFF))
                r_stat_not_taken <= r_stat_not_taken + 16'd1;
            if (w_stall && (r_stat_stall != 16'hFFFF))
                r_stat_stall <= r_stat_stall + 16'd1;
        end
    end

    assign bus.stat_taken        = r_stat_taken;
    assign bus.stat_not_taken    = r_stat_not_taken;
    assign bus.stat_stall_cycles = r_stat_stall;
`endif
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed table-driven bench for branch_resolve_ctrl, plus hand sequences
// for async reset mid-stall and (with BRANCH_STATS_EN) the statistics counters.
module tb_branch_resolve_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    branch_resolve_ctrl_if bus();

    branch_resolve_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       beq, bne;
        logic [4:0] rs, rt;
        logic       exw, exm;
        logic [4:0] exd;
        logic       mw, mm;
        logic [4:0] md;
        logic       ww;
        logic [4:0] wd;
        logic       cmp;
        logic [1:0] fa, fb;
        logic       st, pc;
    } vec_t;

    vec_t vq[$];
    vec_t sq[$];

    function automatic vec_t mkv(input int beq, bne, rs, rt, exw, exm, exd,
                                 mw, mm, md, ww, wd, cmp, fa, fb, st, pc);
        vec_t v;
        v.beq = 1'(beq); v.bne = 1'(bne); v.rs = 5'(rs); v.rt = 5'(rt);
        v.exw = 1'(exw); v.exm = 1'(exm); v.exd = 5'(exd);
        v.mw = 1'(mw); v.mm = 1'(mm); v.md = 5'(md);
        v.ww = 1'(ww); v.wd = 5'(wd); v.cmp = 1'(cmp);
        v.fa = 2'(fa); v.fb = 2'(fb); v.st = 1'(st); v.pc = 1'(pc);
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.id_beq = v.beq; bus.id_bne = v.bne; bus.id_rs = v.rs; bus.id_rt = v.rt;
        bus.ex_reg_write = v.exw; bus.ex_mem_read = v.exm; bus.ex_rd = v.exd;
        bus.mem_reg_write = v.mw; bus.mem_mem_read = v.mm; bus.mem_rd = v.md;
        bus.wb_reg_write = v.ww; bus.wb_rd = v.wd; bus.cmp_equal = v.cmp;
    endtask

    task automatic check_out(input string name, input logic [6:0] exp);
        logic [6:0] got;
        got = {bus.fwd_a_sel, bus.fwd_b_sel, bus.stall, bus.pc_src, bus.if_flush};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got {fa,fb,stall,pc_src,flush}=%b expected %b", name, got, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Drive one cycle, sample mid-cycle, then step past the rising edge.
    task automatic apply(input vec_t v, input string name);
        drive(v);
        @(negedge clk);
        check_out(name, {v.fa, v.fb, v.st, v.pc, v.pc});
        checks++;
        if (bus.stall && bus.pc_src) begin
            failures++;
            $display("FAIL %s_excl: stall=1 and pc_src=1 together, required not both", name);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        //             beq bne rs rt exw exm exd mw mm md ww wd cmp fa fb st pc
        vq.push_back(mkv(0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
        vq.push_back(mkv(1, 0, 4, 5,  0, 0, 0,  0, 0, 0, 0, 0, 1,  0, 0, 0, 1));
        vq.push_back(mkv(0, 1, 4, 5,  0, 0, 0,  0, 0, 0, 0, 0, 1,  0, 0, 0, 0));
        vq.push_back(mkv(0, 1, 4, 5,  0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 1));
        vq.push_back(mkv(1, 0, 4, 5,  1, 0, 4,  0, 0, 0, 0, 0, 1,  0, 0, 1, 0));
        vq.push_back(mkv(1, 0, 4, 5,  0, 0, 0,  1, 0, 4, 0, 0, 0,  1, 0, 0, 0));
        vq.push_back(mkv(1, 0, 4, 5,  1, 0, 4,  0, 0, 0, 0, 0, 0,  0, 0, 1, 0));
        vq.push_back(mkv(1, 0, 4, 5,  0, 0, 0,  1, 0, 4, 0, 0, 1,  1, 0, 0, 1));
        vq.push_back(mkv(1, 0, 4, 5,  1, 1, 5,  0, 0, 0, 0, 0, 1,  0, 0, 1, 0));
        vq.push_back(mkv(1, 0, 4, 5,  0, 0, 0,  1, 1, 5, 0, 0, 1,  0, 0, 1, 0));
        vq.push_back(mkv(1, 0, 4, 5,  0, 0, 0,  0, 0, 0, 1, 5, 1,  0, 2, 0, 1));
        vq.push_back(mkv(1, 0, 0, 5,  1, 0, 0,  1, 0, 0, 1, 0, 1,  0, 0, 0, 1));
        vq.push_back(mkv(1, 0, 4, 6,  0, 0, 0,  1, 1, 6, 0, 0, 1,  0, 0, 1, 0));
        vq.push_back(mkv(1, 0, 4, 6,  0, 0, 0,  0, 0, 0, 1, 6, 0,  0, 2, 0, 0));
        vq.push_back(mkv(1, 0, 7, 7,  0, 0, 0,  1, 0, 7, 1, 7, 1,  1, 1, 0, 1));
        vq.push_back(mkv(1, 0, 3, 5,  1, 1, 3,  0, 0, 0, 0, 0, 1,  0, 0, 1, 0));
        vq.push_back(mkv(0, 0, 3, 5,  0, 0, 0,  1, 1, 3, 0, 0, 1,  0, 0, 0, 0));
        vq.push_back(mkv(1, 0, 4, 5,  0, 0, 0,  0, 0, 0, 0, 0, 1,  0, 0, 0, 1));
        vq.push_back(mkv(1, 0, 8, 9,  0, 0, 0,  0, 0, 9, 0, 8, 0,  0, 0, 0, 0));
        vq.push_back(mkv(1, 0, 10, 11, 0, 1, 10, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1));
        vq.push_back(mkv(1, 0, 4, 5,  1, 0, 4,  0, 0, 0, 0, 0, 1,  0, 0, 1, 0));
        vq.push_back(mkv(0, 0, 4, 5,  0, 0, 0,  1, 0, 4, 0, 0, 1,  0, 0, 0, 0));
        vq.push_back(mkv(0, 1, 4, 5,  0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 1));

        // 3 taken, 2 not taken, 1+2+1 = 4 stall cycles
        sq.push_back(mkv(1, 0, 4, 5,  1, 0, 4,  0, 0, 0, 0, 0, 1,  0, 0, 1, 0));
        sq.push_back(mkv(1, 0, 4, 5,  0, 0, 0,  1, 0, 4, 0, 0, 1,  1, 0, 0, 1));
        sq.push_back(mkv(1, 0, 4, 5,  1, 1, 5,  0, 0, 0, 0, 0, 1,  0, 0, 1, 0));
        sq.push_back(mkv(1, 0, 4, 5,  0, 0, 0,  1, 1, 5, 0, 0, 1,  0, 0, 1, 0));
        sq.push_back(mkv(1, 0, 4, 5,  0, 0, 0,  0, 0, 0, 1, 5, 1,  0, 2, 0, 1));
        sq.push_back(mkv(1, 0, 4, 5,  1, 0, 4,  0, 0, 0, 0, 0, 0,  0, 0, 1, 0));
        sq.push_back(mkv(1, 0, 4, 5,  0, 0, 0,  1, 0, 4, 0, 0, 0,  1, 0, 0, 0));
        sq.push_back(mkv(1, 0, 4, 5,  0, 0, 0,  0, 0, 0, 0, 0, 1,  0, 0, 0, 1));
        sq.push_back(mkv(1, 0, 4, 5,  0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
        sq.push_back(mkv(0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0));

        // Reset held: even a resolvable branch must produce no outputs.
        drive(mkv(1, 0, 4, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        #2;
        check_out("reset_hold", 7'b0);
`ifdef BRANCH_STATS_EN
        check_val("reset_stat_taken", bus.stat_taken, 16'd0);
        check_val("reset_stat_not_taken", bus.stat_not_taken, 16'd0);
        check_val("reset_stat_stall", bus.stat_stall_cycles, 16'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (vq[i]) apply(vq[i], $sformatf("vec%0d", i));

        // Async reset in the first STALL cycle of a load-in-EX hazard.
        apply(mkv(1, 0, 4, 5, 1, 1, 5, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0), "rst_seq_enter");
        drive(mkv(1, 0, 4, 5, 0, 0, 0, 1, 1, 5, 0, 0, 1, 0, 0, 0, 0));
        #1;
        check_out("rst_seq_stall", 7'b0000100);
        rst_n = 1'b0;
        #1;
        check_out("rst_seq_abort", 7'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply(mkv(1, 0, 4, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1), "rst_seq_after");

`ifdef BRANCH_STATS_EN
        rst_n = 1'b0;
        #2;
        check_val("stat_clear", bus.stat_taken, 16'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        foreach (sq[i]) apply(sq[i], $sformatf("stat_vec%0d", i));
        check_val("stat_taken", bus.stat_taken, 16'd3);
        check_val("stat_not_taken", bus.stat_not_taken, 16'd2);
        check_val("stat_stall_cycles", bus.stat_stall_cycles, 16'd4);
`else
        foreach (sq[i]) apply(sq[i], $sformatf("seq_vec%0d", i));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/branch_resolve_ctrl.md
# branch_resolve_ctrl

ID-stage branch controller for the pipelined MIPS core. It sequences the 32-bit equality comparator that resolves `beq`/`bne` in decode. It detects operand hazards against the EX/MEM pipeline, stalls the front end until the operands are available, and steers the comparator's operand forwarding muxes. It then samples the comparator result and drives PC redirect plus the IF/ID flush.

## Interface
- No parameters; register specifier width fixed at 5, data path not touched by this block.
- `clk` in 1: pipeline clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_beq`, `id_bne` in 1 each: decoded branch in ID; at most one high.
- `id_rs`, `id_rt` in 5 each: branch source registers.
- `ex_reg_write`, `ex_mem_read` in 1 each; `ex_rd` in 5: ID/EX producer info.
- `mem_reg_write`, `mem_mem_read` in 1 each; `mem_rd` in 5: EX/MEM producer info.
- `wb_reg_write` in 1; `wb_rd` in 5: MEM/WB producer info.
- `cmp_equal` in 1: comparator output; valid by end of cycle.
- `fwd_a_sel`, `fwd_b_sel` out 2 each: comparator operand select. `00` = regfile, `01` = EX/MEM ALU result, `10` = WB data.
- `stall` out 1: freeze PC and IF/ID, bubble into ID/EX.
- `pc_src` out 1: select branch target this cycle.
- `if_flush` out 1: zero IF/ID on next edge.

## Operation
- Branch = `id_beq | id_bne`. Match(r, x) = `x != 0 && x == r`, checked for `id_rs` or `id_rt`.
- Hazard count `need`:
  - 2 if `ex_reg_write & ex_mem_read` and match on `ex_rd`.
  - Else 1 if `ex_reg_write` matches `ex_rd`.
  - Else 1 if `mem_mem_read` matches `mem_rd`.
  - Else 0.
- FSM states: IDLE, STALL, RESOLVE.
  - **IDLE**
    - If no branch: all outputs 0.
    - If branch with `need==0`: resolve in this cycle and stay in IDLE.
    - If branch with `need>0`: `stall=1`, load `cnt<=need-1`. Next state is RESOLVE if `need==1`, else STALL.
  - **STALL:** `stall=1`, `cnt<=cnt-1`. When `cnt==1`, go to RESOLVE.
  - **RESOLVE:** `stall=0`, resolve, then go to IDLE.
- Resolve (combinational in that cycle):
  - `pc_src = cmp_equal ^ id_bne`.
  - `if_flush = pc_src`.
- Forwarding select, per operand, valid whenever resolving:
  - `01` if `mem_reg_write & ~mem_mem_read` and match on `mem_rd`.
  - Else `10` if `wb_reg_write` and match on `wb_rd`.
  - Else `00`.
  - Outside resolve cycles the select is `00`.
- The `need` value and stall length are not re-evaluated during STALL. IF/ID is frozen, and the producer advances one stage per bubble.
- Branch deasserted while in STALL or RESOLVE: return to IDLE next edge with `pc_src=0`. This is a defensive abort.
- `stall` and `pc_src` are never high in the same cycle.

## Timing
- Reset (async, `rst_n=0`): state IDLE, `cnt=0`. All outputs 0, including stat counters.
- Reset asserted mid-STALL aborts immediately; no redirect is issued.
- Latency from branch entering ID to `pc_src`:
  - 0 cycles for an independent branch.
  - 1 cycle after an ALU producer in EX or a load in MEM.
  - 2 cycles after a load in EX.
- `stall` is high for exactly `need` cycles.
- Outputs are combinational from state, `cnt`, and inputs. State and `cnt` update on the rising edge.
- `$zero` (register 0) never causes a hazard or forward.
- `id_rs == id_rt` is legal; both selects are computed identically.

## Configuration
- `BRANCH_STATS_EN` defined: adds outputs `stat_taken`, `stat_not_taken`, `stat_stall_cycles`, 16 bits each.
  - `stat_taken` / `stat_not_taken` increment on each resolve cycle according to `pc_src`.
  - `stat_stall_cycles` increments on each `stall=1` cycle.
  - All three saturate at `16'hFFFF`, reset to 0, and have no clear input.
- `BRANCH_STATS_EN` undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Test plan
- Independent operands, no hazard:
  - `beq`, rs=4, rt=5, `cmp_equal=1`, no producers -> same cycle `stall=0`, `pc_src=1`, `if_flush=1`, selects `00`.
  - `bne` with `cmp_equal=1` -> `pc_src=0`.
- ALU producer in EX: `ex_reg_write=1`, `ex_rd=4`, `beq` rs=4 -> `stall=1` for 1 cycle. Then, with `mem_rd=4`, `mem_reg_write=1`: `fwd_a_sel=01`, and `pc_src` follows `cmp_equal`.
- Load in EX: `ex_mem_read=1`, `ex_rd=5`, rt=5 -> `stall=1` for 2 cycles, then RESOLVE with `wb_rd=5`, `fwd_b_sel=10`.
- `$zero` source: `ex_rd=0`, rs=0, `ex_reg_write=1` -> no stall, `fwd_a_sel=00`.
- Async reset: pull `rst_n` low in the first STALL cycle of a load hazard -> all outputs 0 immediately. After release, a new independent `beq` resolves with zero latency.
- Stats (`BRANCH_STATS_EN`): run 3 taken and 2 not-taken branches with 4 total stall cycles -> counters read 3 / 2 / 4.
